decode: RTL and testbench

DECODE -- requirements
Module: decode

---
 rtl/decode_pkg.sv | 76 +++++++
 rtl/register_file.sv | 38 +++
 rtl/decode.sv | 100 ++++++++++
 tb/tb_decode.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - op_class / immediate-type enums, opcode constants and decode helpers
package decode_pkg;

  typedef enum logic [3:0] {
    CLS_LUI      = 4'd0,
    CLS_AUIPC    = 4'd1,
    CLS_JAL      = 4'd2,
    CLS_JALR     = 4'd3,
    CLS_BRANCH   = 4'd4,
    CLS_LOAD     = 4'd5,
    CLS_STORE    = 4'd6,
    CLS_OP_IMM   = 4'd7,
    CLS_OP       = 4'd8,
    CLS_MISC_MEM = 4'd9,
    CLS_SYSTEM   = 4'd10,
    CLS_ILLEGAL  = 4'd11
  } op_class_e;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_type_e;

  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

  // Full 7-bit compare also rejects compressed encodings (ins[1:0] != 2'b11).
  function automatic op_class_e classify(input logic [6:0] opcode);
    case (opcode)
      OPCODE_LUI:      return CLS_LUI;
      OPCODE_AUIPC:    return CLS_AUIPC;
      OPCODE_JAL:      return CLS_JAL;
      OPCODE_JALR:     return CLS_JALR;
      OPCODE_BRANCH:   return CLS_BRANCH;
      OPCODE_LOAD:     return CLS_LOAD;
      OPCODE_STORE:    return CLS_STORE;
      OPCODE_OP_IMM:   return CLS_OP_IMM;
      OPCODE_OP:       return CLS_OP;
      OPCODE_MISC_MEM: return CLS_MISC_MEM;
      OPCODE_SYSTEM:   return CLS_SYSTEM;
      default:         return CLS_ILLEGAL;
    endcase
  endfunction

  function automatic imm_type_e imm_type_of(input op_class_e cls);
    case (cls)
      CLS_LUI, CLS_AUIPC:                    return IMM_U;
      CLS_JAL:                               return IMM_J;
      CLS_BRANCH:                            return IMM_B;
      CLS_STORE:                             return IMM_S;
      CLS_JALR, CLS_LOAD, CLS_OP_IMM,
      CLS_MISC_MEM, CLS_SYSTEM:              return IMM_I;
      default:                               return IMM_NONE;
    endcase
  endfunction

  function automatic logic [31:0] imm_gen(input logic [31:0] ins, input imm_type_e t);
    case (t)
      IMM_I:   return {{20{ins[31]}}, ins[31:20]};
      IMM_S:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   return {ins[31:12], 12'b0};
      IMM_J:   return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/register_file.sv
// rtl/register_file.sv - 32x32 register file, two combinational reads, one write; WB_BYPASS_EN adds write-to-read bypass
module register_file (
  input  logic        clk,
  input  logic [4:0]  rs1_index,
  input  logic [4:0]  rs2_index,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        wr_en,
  input  logic [4:0]  wr_index,
  input  logic [31:0] wr_data
);

  // Storage is intentionally not reset; x0 is forced to zero on the read side.
  logic [31:0] mem [32];

  always_ff @(posedge clk) begin
    if (wr_en && wr_index != 5'd0) begin
      mem[wr_index] <= wr_data;
    end
  end

`ifdef WB_BYPASS_EN
  always_comb begin
    rs1_data = mem[rs1_index];
    rs2_data = mem[rs2_index];
    if (wr_en && wr_index == rs1_index) rs1_data = wr_data;
    if (wr_en && wr_index == rs2_index) rs2_data = wr_data;
    if (rs1_index == 5'd0) rs1_data = 32'd0;
    if (rs2_index == 5'd0) rs2_data = 32'd0;
  end
`else
  always_comb begin
    rs1_data = (rs1_index == 5'd0) ? 32'd0 : mem[rs1_index];
    rs2_data = (rs2_index == 5'd0) ? 32'd0 : mem[rs2_index];
  end
`endif

endmodule

// File: rtl/decode.sv
// rtl/decode.sv - decode stage: classify, immediate, register read, load-use hazard, id_ex pipeline register
// Optional WB_BYPASS_EN selects same-cycle writeback bypass in the register file.
module decode
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_id__ins,
  input  logic [31:0] if_id__pc,
  input  logic        if_id__ins_misalign,
  input  logic        if_id__predict_taken,
  input  logic        pipe_flush,
  input  logic        id_ex__mem_read,
  input  logic        wb__rd_we,
  input  logic [4:0]  wb__rd_index,
  input  logic [31:0] wb__rd_data,
  output logic        data_hazard,
  output logic        id_ex__valid,
  output logic [31:0] id_ex__pc,
  output logic        id_ex__ins_misalign,
  output logic        id_ex__predict_taken,
  output logic [31:0] id_ex__rs1_data,
  output logic [31:0] id_ex__rs2_data,
  output logic [31:0] id_ex__imm,
  output logic [4:0]  id_ex__rs1_index,
  output logic [4:0]  id_ex__rs2_index,
  output logic [4:0]  id_ex__rd_index,
  output logic [3:0]  id_ex__op_class,
  output logic [2:0]  id_ex__funct3,
  output logic        id_ex__funct7_5,
  output logic        id_ex__illegal
);

  logic [4:0]  rs1_index, rs2_index, rd_index;
  logic [31:0] rs1_data, rs2_data, imm;
  logic        uses_rs1, uses_rs2;
  op_class_e   op_class;

  assign rs1_index = if_id__ins[19:15];
  assign rs2_index = if_id__ins[24:20];
  assign rd_index  = if_id__ins[11:7];
  assign op_class  = classify(if_id__ins[6:0]);
  assign imm       = imm_gen(if_id__ins, imm_type_of(op_class));

  assign uses_rs1 = !(op_class inside {CLS_LUI, CLS_AUIPC, CLS_JAL});
  assign uses_rs2 = op_class inside {CLS_BRANCH, CLS_STORE, CLS_OP};

  // The load in execute is identified by this stage's own registered rd/valid.
  assign data_hazard = !pipe_flush && id_ex__valid && id_ex__mem_read &&
                       (id_ex__rd_index != 5'd0) &&
                       ((uses_rs1 && rs1_index == id_ex__rd_index) ||
                        (uses_rs2 && rs2_index == id_ex__rd_index));

  register_file u_register_file (
    .clk       (clk),
    .rs1_index (rs1_index),
    .rs2_index (rs2_index),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .wr_en     (wb__rd_we),
    .wr_index  (wb__rd_index),
    .wr_data   (wb__rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex__valid         <= 1'b0;
      id_ex__pc            <= '0;
      id_ex__ins_misalign  <= 1'b0;
      id_ex__predict_taken <= 1'b0;
      id_ex__rs1_data      <= '0;
      id_ex__rs2_data      <= '0;
      id_ex__imm           <= '0;
      id_ex__rs1_index     <= '0;
      id_ex__rs2_index     <= '0;
      id_ex__rd_index      <= '0;
      id_ex__op_class      <= '0;
      id_ex__funct3        <= '0;
      id_ex__funct7_5      <= 1'b0;
      id_ex__illegal       <= 1'b0;
    end else begin
      // Bubbles still load the payload; only valid is gated.
      id_ex__valid         <= !(pipe_flush || data_hazard);
      id_ex__pc            <= if_id__pc;
      id_ex__ins_misalign  <= if_id__ins_misalign;
      id_ex__predict_taken <= if_id__predict_taken;
      id_ex__rs1_data      <= rs1_data;
      id_ex__rs2_data      <= rs2_data;
      id_ex__imm           <= imm;
      id_ex__rs1_index     <= rs1_index;
      id_ex__rs2_index     <= rs2_index;
      id_ex__rd_index      <= rd_index;
      id_ex__op_class      <= op_class;
      id_ex__funct3        <= if_id__ins[14:12];
      id_ex__funct7_5      <= if_id__ins[30];
      id_ex__illegal       <= (op_class == CLS_ILLEGAL);
    end
  end

endmodule

// File: tb/tb_decode.sv
// tb/tb_decode.sv - directed self-checking bench for decode
module tb_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ins, pc;
  logic        ins_misalign, predict_taken, pipe_flush, mem_read;
  logic        wb_we;
  logic [4:0]  wb_index;
  logic [31:0] wb_data;
  logic        data_hazard, valid, o_misalign, o_predict, funct7_5, illegal;
  logic [31:0] o_pc, rs1_data, rs2_data, imm;
  logic [4:0]  rs1_index, rs2_index, rd_index;
  logic [3:0]  op_class;
  logic [2:0]  funct3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .if_id__ins           (ins),
    .if_id__pc            (pc),
    .if_id__ins_misalign  (ins_misalign),
    .if_id__predict_taken (predict_taken),
    .pipe_flush           (pipe_flush),
    .id_ex__mem_read      (mem_read),
    .wb__rd_we            (wb_we),
    .wb__rd_index         (wb_index),
    .wb__rd_data          (wb_data),
    .data_hazard          (data_hazard),
    .id_ex__valid         (valid),
    .id_ex__pc            (o_pc),
    .id_ex__ins_misalign  (o_misalign),
    .id_ex__predict_taken (o_predict),
    .id_ex__rs1_data      (rs1_data),
    .id_ex__rs2_data      (rs2_data),
    .id_ex__imm           (imm),
    .id_ex__rs1_index     (rs1_index),
    .id_ex__rs2_index     (rs2_index),
    .id_ex__rd_index      (rd_index),
    .id_ex__op_class      (op_class),
    .id_ex__funct3        (funct3),
    .id_ex__funct7_5      (funct7_5),
    .id_ex__illegal       (illegal)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ins = 32'h0; pc = 32'h0; ins_misalign = 1'b0; predict_taken = 1'b0;
    pipe_flush = 1'b0; mem_read = 1'b0; wb_we = 1'b0; wb_index = 5'd0; wb_data = 32'h0;
    #2;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %h exp 0", valid); end
    checks++; if (data_hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard got %h exp 0", data_hazard); end
    step();
    checks++; if ({o_pc, imm, rd_index, op_class, illegal} !== '0) begin
      errors++; $display("FAIL reset_payload got pc=%h imm=%h rd=%0d cls=%0d ill=%b exp all 0", o_pc, imm, rd_index, op_class, illegal);
    end
    rst_n = 1'b1;
    ins = 32'h0000_0013;
    step();
  endtask

  task automatic test_addi();
    ins = 32'hFFB0_0093; pc = 32'h0000_0100; predict_taken = 1'b1;
    step();
    predict_taken = 1'b0;
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %h exp 1", valid); end
    checks++; if (op_class !== 4'd7) begin errors++; $display("FAIL addi_class got %0d exp 7", op_class); end
    checks++; if (imm !== 32'hFFFF_FFFB) begin errors++; $display("FAIL addi_imm got %h exp fffffffb", imm); end
    checks++; if (rd_index !== 5'd1) begin errors++; $display("FAIL addi_rd got %0d exp 1", rd_index); end
    checks++; if (o_pc !== 32'h100 || o_predict !== 1'b1) begin errors++; $display("FAIL addi_pc got %h/%b exp 100/1", o_pc, o_predict); end
    checks++; if (rs1_data !== 32'h0 || illegal !== 1'b0) begin errors++; $display("FAIL addi_x0 got %h/%b exp 0/0", rs1_data, illegal); end
  endtask

  task automatic test_reg_read();
    ins = 32'h0000_0013;
    wb_we = 1'b1; wb_index = 5'd5; wb_data = 32'h1234;
    step();
    wb_we = 1'b0;
    ins = 32'h0052_8333;
    step();
    checks++; if (rs1_data !== 32'h1234 || rs2_data !== 32'h1234) begin
      errors++; $display("FAIL add_operands got %h/%h exp 1234/1234", rs1_data, rs2_data);
    end
    checks++; if (op_class !== 4'd8 || imm !== 32'h0 || rd_index !== 5'd6) begin
      errors++; $display("FAIL add_decode got cls=%0d imm=%h rd=%0d exp 8/0/6", op_class, imm, rd_index);
    end
    // x0 writes are dropped.
    wb_we = 1'b1; wb_index = 5'd0; wb_data = 32'hDEAD;
    ins = 32'h0000_0013;
    step();
    wb_we = 1'b0;
    ins = 32'h0000_0033;
    step();
    checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL x0_write got %h exp 0", rs1_data); end
  endtask

  task automatic test_branch_imm();
    ins = 32'hFE00_0CE3;
    step();
    checks++; if (op_class !== 4'd4 || imm !== 32'hFFFF_FFF8) begin
      errors++; $display("FAIL beq_imm got cls=%0d imm=%h exp 4/fffffff8", op_class, imm);
    end
  endtask

  task automatic test_load_use();
    ins = 32'h0000_A383;
    step();
    checks++; if (valid !== 1'b1 || op_class !== 4'd5 || rd_index !== 5'd7) begin
      errors++; $display("FAIL lw_issue got v=%b cls=%0d rd=%0d exp 1/5/7", valid, op_class, rd_index);
    end
    mem_read = 1'b1;
    ins = 32'h0003_8433;
    #1;
    checks++; if (data_hazard !== 1'b1) begin errors++; $display("FAIL load_use_hazard got %b exp 1", data_hazard); end
    step();
    checks++; if (valid !== 1'b0 || data_hazard !== 1'b0) begin
      errors++; $display("FAIL load_use_bubble got v=%b hz=%b exp 0/0", valid, data_hazard);
    end
    mem_read = 1'b0;
    step();
    checks++; if (valid !== 1'b1 || rd_index !== 5'd8 || rs1_index !== 5'd7) begin
      errors++; $display("FAIL load_use_issue got v=%b rd=%0d rs1=%0d exp 1/8/7", valid, rd_index, rs1_index);
    end
  endtask

  task automatic test_lui_no_hazard();
    ins = 32'h0000_A383;
    step();
    mem_read = 1'b1;
    ins = 32'h0003_83B7;
    #1;
    checks++; if (data_hazard !== 1'b0) begin errors++; $display("FAIL lui_hazard got %b exp 0", data_hazard); end
    step();
    mem_read = 1'b0;
    checks++; if (valid !== 1'b1 || op_class !== 4'd0 || imm !== 32'h0003_8000) begin
      errors++; $display("FAIL lui_issue got v=%b cls=%0d imm=%h exp 1/0/00038000", valid, op_class, imm);
    end
  endtask

  task automatic test_flush_hazard();
    ins = 32'h0000_A383;
    step();
    mem_read = 1'b1;
    ins = 32'h0003_8433;
    pipe_flush = 1'b1;
    #1;
    checks++; if (data_hazard !== 1'b0) begin errors++; $display("FAIL flush_hazard got %b exp 0", data_hazard); end
    step();
    pipe_flush = 1'b0; mem_read = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", valid); end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_same;
    ins = 32'h0000_0013;
    wb_we = 1'b1; wb_index = 5'd3; wb_data = 32'h11;
    step();
    wb_data = 32'hAA;
    ins = 32'h0001_8233;
    step();
    wb_we = 1'b0;
`ifdef WB_BYPASS_EN
    exp_same = 32'hAA;
`else
    exp_same = 32'h11;
`endif
    checks++; if (rs1_data !== exp_same) begin errors++; $display("FAIL wb_same_cycle got %h exp %h", rs1_data, exp_same); end
    step();
    checks++; if (rs1_data !== 32'hAA) begin errors++; $display("FAIL wb_after got %h exp aa", rs1_data); end
  endtask

  task automatic test_illegal();
    ins = 32'h0000_0000; ins_misalign = 1'b1;
    step();
    ins_misalign = 1'b0;
    checks++; if (illegal !== 1'b1 || valid !== 1'b1 || op_class !== 4'd11 || imm !== 32'h0 || o_misalign !== 1'b1) begin
      errors++; $display("FAIL illegal_zero got ill=%b v=%b cls=%0d imm=%h mis=%b exp 1/1/11/0/1", illegal, valid, op_class, imm, o_misalign);
    end
    ins = 32'hFFB0_0090;
    step();
    checks++; if (illegal !== 1'b1 || op_class !== 4'd11) begin
      errors++; $display("FAIL illegal_low_bits got ill=%b cls=%0d exp 1/11", illegal, op_class);
    end
  endtask

  task automatic test_reset_mid();
    ins = 32'h0000_A383; pc = 32'h0000_0200;
    step();
    mem_read = 1'b1;
    ins = 32'h0003_8433;
    #1;
    checks++; if (data_hazard !== 1'b1) begin errors++; $display("FAIL mid_pre_hazard got %b exp 1", data_hazard); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (valid !== 1'b0 || data_hazard !== 1'b0) begin
      errors++; $display("FAIL mid_reset_ctrl got v=%b hz=%b exp 0/0", valid, data_hazard);
    end
    checks++; if ({o_pc, imm, rd_index, rs1_index, op_class, rs1_data} !== '0) begin
      errors++; $display("FAIL mid_reset_payload got pc=%h imm=%h rd=%0d rs1=%0d cls=%0d exp all 0", o_pc, imm, rd_index, rs1_index, op_class);
    end
    mem_read = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_reg_read();
    test_branch_imm();
    test_load_use();
    test_lui_no_hazard();
    test_flush_hazard();
    test_bypass();
    test_illegal();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
